hbridge_guard: RTL and testbench
================================

HBRIDGE_GUARD -- requirements
Module: hbridge_guard

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 100000, meaning MCLK cycles of forced coast before any new drive direction (1 ms at 100 MHz).
REQ-002 SHALL have parameter CNT_W, default 17, meaning dead-time counter width; DEAD_CYCLES SHALL be at least 1 and at most 2^CNT_W-1.
REQ-003 SHALL have port MCLK input 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port nRST input 1: synchronous, active-low reset.
REQ-005 SHALL have port EnA_in / EnB_in input 1: PWM enables from the drive system.
REQ-006 SHALL have port MotorA_in / MotorB_in input 2: requested code; 10 = forward, 01 = reverse, 00 = coast, 11 = brake.
REQ-007 SHALL have port KillA / KillB input 1: overcurrent kill, level-sensitive, per channel.
REQ-008 SHALL have port EnA / EnB output 1: gated enables to the H-bridge.
REQ-009 SHALL have port MotorA / MotorB output 2: applied direction code to the H-bridge.
REQ-010 SHALL have port BusyA / BusyB output 1: high while the channel is not in RUN.

Function
REQ-011 SHALL implement two identical, independent channels, A and B; the rules below are per channel.
REQ-012 SHALL register all outputs, giving one MCLK cycle of latency from input to output.
REQ-013 SHALL use states RUN, DEAD, FAULT, with a CNT_W-bit counter and a 2-bit target register.
REQ-014 In RUN, Motor SHALL equal the applied code, En SHALL equal the previous-cycle En_in, and Busy SHALL be 0.
REQ-015 In RUN, a Motor_in of 00 or 11 that differs from the applied code SHALL be applied on the next cycle, with no dead time.
REQ-016 In RUN, a Motor_in of 10 or 01 that differs from the applied code SHALL:
- enter DEAD;
- latch the target;
- load the counter with DEAD_CYCLES-1.
REQ-017 In DEAD, outputs SHALL be Motor=00, En=0, Busy=1, and the counter SHALL decrement once per cycle.
REQ-018 In DEAD with counter=0, the channel SHALL enter RUN and apply the target; that cycle SHALL give exactly DEAD_CYCLES coast cycles.
REQ-019 In DEAD, a Motor_in of 10 or 01 different from the target SHALL retarget without restarting the counter.
REQ-020 In DEAD, a Motor_in of 00 or 11 SHALL abort to RUN with that code on the next cycle.
REQ-021 Kill=1 in any state SHALL enter FAULT on the next cycle.
REQ-022 In FAULT, outputs SHALL be Motor=00, En=0, Busy=1; Kill has priority over all other events in the same cycle.
REQ-023 When Kill falls in FAULT:
- Motor_in of 10 or 01 SHALL enter DEAD with a full count and target=Motor_in;
- otherwise the channel SHALL enter RUN with Motor_in.
REQ-024 MotorA and MotorB SHALL never be 10 and 01 (or 01 and 10) on consecutive cycles within one channel.

Reset
REQ-025 nRST=0 at a rising MCLK edge SHALL force state RUN, applied=00, target=00, counter=0, and outputs En=0, Motor=00, Busy=0.
REQ-026 Reset mid-DEAD or mid-FAULT SHALL abandon the pending target.
REQ-027 After reset release, the first drive request SHALL take the REQ-016 path, because applied=00 differs from it.

Structure
REQ-028 Motor code constants (FWD, REV, COAST, BRAKE) and state encodings SHALL reside in a shared package/include used by the movement system as well.
REQ-029 The top level SHALL instantiate sub-module hbridge_channel twice.
REQ-030 hbridge_channel SHALL hold the FSM, counter and output registers; the top SHALL contain no logic beyond wiring.
REQ-031 The implementation SHALL be 120-400 lines of RTL.

Verification
All scenarios use DEAD_CYCLES=4.
REQ-032 Reset then MotorA_in=10, EnA_in=1: BusyA=1 and MotorA=00 for 4 cycles, then MotorA=10 and EnA=1.
REQ-033 From RUN at 10, set MotorA_in=01: EnA=0 and MotorA=00 for exactly 4 cycles, then MotorA=01; channel B unaffected.
REQ-034 From RUN at 10, set MotorA_in=00, then 11: MotorA follows next cycle with BusyA never asserted.
REQ-035 MotorA_in 10→01 during RUN at 10, then 10 again at DEAD cycle 2: MotorA=10 after the original 4-cycle window, with no restart.
REQ-036 Assert KillB for 3 cycles while running 01: EnB=0 and MotorB=00 during kill, then 4 coast cycles, then MotorB=01.
REQ-037 Pulse nRST=0 at DEAD cycle 2: the next cycle shows MotorA=00, BusyA=0, and the old target is never applied.

Source files
------------

// File: rtl/hbridge_guard_pkg.sv
// hbridge_guard_pkg
//   Motor direction codes and channel state encodings. The drive system uses
//   the same package, so the direction codes are defined in this one place.
//   No ports: this file holds only types and a helper function.
package hbridge_guard_pkg;

    typedef enum logic [1:0] {
        COAST = 2'b00,
        REV   = 2'b01,
        FWD   = 2'b10,
        BRAKE = 2'b11
    } motorCode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DEAD  = 2'b01,
        ST_FAULT = 2'b10
    } chanState_e;

    // Returns 1 for the two codes that actively drive current through the
    // bridge. Only these need a dead time before they are applied.
    function automatic logic isDrive(input logic [1:0] code);
        return (code == FWD) || (code == REV);
    endfunction

endpackage

// File: rtl/hbridge_channel.sv
// hbridge_channel
//   Guards one H-bridge channel. A change to a new drive direction is
//   preceded by DEAD_CYCLES cycles of forced coast. Coast and brake requests
//   are applied at once. A kill input forces coast until it is released.
//   Every output is registered, so an input change shows up one cycle later.
// Ports
//   MCLK     : clock, all logic on its rising edge
//   nRST     : synchronous active-low reset
//   enIn     : PWM enable from the drive system
//   motorIn  : requested direction code
//   kill     : overcurrent kill, level-sensitive
//   en       : gated enable to the bridge
//   motor    : applied direction code to the bridge
//   busy     : high whenever the channel is not in RUN
module hbridge_channel
    import hbridge_guard_pkg::*;
#(
    parameter int DEAD_CYCLES = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       MCLK,
    input  logic       nRST,
    input  logic       enIn,
    input  logic [1:0] motorIn,
    input  logic       kill,
    output logic       en,
    output logic [1:0] motor,
    output logic       busy
);

    // The count is loaded with DEAD_CYCLES-1. The cycle on which it reads
    // zero is the last coast cycle, which gives exactly DEAD_CYCLES cycles
    // of coast.
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

    chanState_e       state;
    logic [1:0]       applied;
    logic [1:0]       target;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge MCLK) begin
        if (!nRST) begin
            state   <= ST_RUN;
            applied <= COAST;
            target  <= COAST;
            cnt     <= '0;
            en      <= 1'b0;
            motor   <= COAST;
            busy    <= 1'b0;
        end else if (kill) begin
            // The bridge is coasting now, so treat the applied code as coast.
            // The first drive request after release then gets a full dead time.
            state   <= ST_FAULT;
            applied <= COAST;
            target  <= COAST;
            cnt     <= '0;
            en      <= 1'b0;
            motor   <= COAST;
            busy    <= 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (isDrive(motorIn) && (motorIn != applied)) begin
                        state  <= ST_DEAD;
                        target <= motorIn;
                        cnt    <= DEAD_LOAD;
                        en     <= 1'b0;
                        motor  <= COAST;
                        busy   <= 1'b1;
                    end else begin
                        applied <= motorIn;
                        en      <= enIn;
                        motor   <= motorIn;
                        busy    <= 1'b0;
                    end
                end

                ST_DEAD: begin
                    if (!isDrive(motorIn)) begin
                        // Coast or brake ends the wait right away.
                        state   <= ST_RUN;
                        applied <= motorIn;
                        en      <= enIn;
                        motor   <= motorIn;
                        busy    <= 1'b0;
                    end else if (cnt == '0) begin
                        // The target was latched on an earlier cycle. If the
                        // request differs now, RUN starts a new dead time.
                        state   <= ST_RUN;
                        applied <= target;
                        en      <= enIn;
                        motor   <= target;
                        busy    <= 1'b0;
                    end else begin
                        // A new direction changes the target but does not
                        // restart the count.
                        cnt    <= cnt - 1'b1;
                        target <= motorIn;
                        en     <= 1'b0;
                        motor  <= COAST;
                        busy   <= 1'b1;
                    end
                end

                ST_FAULT: begin
                    if (isDrive(motorIn)) begin
                        state  <= ST_DEAD;
                        target <= motorIn;
                        cnt    <= DEAD_LOAD;
                        en     <= 1'b0;
                        motor  <= COAST;
                        busy   <= 1'b1;
                    end else begin
                        state   <= ST_RUN;
                        applied <= motorIn;
                        en      <= enIn;
                        motor   <= motorIn;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    state   <= ST_RUN;
                    applied <= COAST;
                    target  <= COAST;
                    cnt     <= '0;
                    en      <= 1'b0;
                    motor   <= COAST;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hbridge_guard.sv
// hbridge_guard
//   A two-channel H-bridge direction guard. Channel A is lane 0 and channel
//   B is lane 1. Each lane is an hbridge_channel instance. This module only
//   does wiring.
// Ports
//   MCLK, nRST            : clock and synchronous active-low reset
//   EnA_in/EnB_in         : PWM enables from the drive system
//   MotorA_in/MotorB_in   : requested direction codes
//   KillA/KillB           : overcurrent kills
//   EnA/EnB               : gated enables to the bridge
//   MotorA/MotorB         : applied direction codes to the bridge
//   BusyA/BusyB           : channel not in RUN
module hbridge_guard
    import hbridge_guard_pkg::*;
#(
    parameter int DEAD_CYCLES = 100000,
    parameter int CNT_W       = 17
) (
    input  logic       MCLK,
    input  logic       nRST,
    input  logic       EnA_in,
    input  logic       EnB_in,
    input  logic [1:0] MotorA_in,
    input  logic [1:0] MotorB_in,
    input  logic       KillA,
    input  logic       KillB,
    output logic       EnA,
    output logic       EnB,
    output logic [1:0] MotorA,
    output logic [1:0] MotorB,
    output logic       BusyA,
    output logic       BusyB
);

    localparam int NUM_LANES = 2;

    logic [NUM_LANES-1:0]      enInV, killV, enV, busyV;
    logic [NUM_LANES-1:0][1:0] motorInV, motorV;

    assign enInV    = {EnB_in, EnA_in};
    assign killV    = {KillB, KillA};
    assign motorInV = {MotorB_in, MotorA_in};

    assign EnA    = enV[0];
    assign EnB    = enV[1];
    assign MotorA = motorV[0];
    assign MotorB = motorV[1];
    assign BusyA  = busyV[0];
    assign BusyB  = busyV[1];

    for (genvar i = 0; i < NUM_LANES; i++) begin : gChan
        hbridge_channel #(
            .DEAD_CYCLES(DEAD_CYCLES),
            .CNT_W      (CNT_W)
        ) uChan (
            .MCLK   (MCLK),
            .nRST   (nRST),
            .enIn   (enInV[i]),
            .motorIn(motorInV[i]),
            .kill   (killV[i]),
            .en     (enV[i]),
            .motor  (motorV[i]),
            .busy   (busyV[i])
        );
    end

endmodule

// File: tb/tb_hbridge_guard.sv
module tb_hbridge_guard;

    localparam int DEAD = 4;

    logic       MCLK = 1'b0;
    logic       nRST = 1'b0;
    logic       EnA_in = 1'b0, EnB_in = 1'b0;
    logic [1:0] MotorA_in = 2'b00, MotorB_in = 2'b00;
    logic       KillA = 1'b0, KillB = 1'b0;
    logic       EnA, EnB, BusyA, BusyB;
    logic [1:0] MotorA, MotorB;

    hbridge_guard #(.DEAD_CYCLES(DEAD), .CNT_W(17)) dut (
        .MCLK(MCLK), .nRST(nRST),
        .EnA_in(EnA_in), .EnB_in(EnB_in),
        .MotorA_in(MotorA_in), .MotorB_in(MotorB_in),
        .KillA(KillA), .KillB(KillB),
        .EnA(EnA), .EnB(EnB),
        .MotorA(MotorA), .MotorB(MotorB),
        .BusyA(BusyA), .BusyB(BusyB)
    );

    always #5 MCLK = ~MCLK;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model per channel. coastLeft counts the forced-coast cycles
    // still owed. pending is the direction to apply when they run out.
    int         coastLeft [2];
    bit         killed    [2];
    logic [1:0] onBridge  [2];
    logic [1:0] pending   [2];
    logic       expEn     [2];
    logic [1:0] expMotor  [2];
    logic       expBusy   [2];
    logic [1:0] prevMotor [2];

    function automatic bit drives(input logic [1:0] c);
        return c == 2'b10 || c == 2'b01;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic runOut(input int ch, input logic [1:0] code, input logic e);
        onBridge[ch] = code;
        expMotor[ch] = code;
        expEn[ch]    = e;
        expBusy[ch]  = 1'b0;
    endtask

    task automatic coastOut(input int ch);
        expMotor[ch] = 2'b00;
        expEn[ch]    = 1'b0;
        expBusy[ch]  = 1'b1;
    endtask

    task automatic model(input int ch, input logic rn, input logic e,
                         input logic [1:0] mi, input logic k);
        if (!rn) begin
            coastLeft[ch] = 0; killed[ch] = 0; onBridge[ch] = 2'b00;
            pending[ch] = 2'b00;
            expEn[ch] = 0; expMotor[ch] = 2'b00; expBusy[ch] = 0;
        end else if (k) begin
            killed[ch] = 1; coastLeft[ch] = 0; onBridge[ch] = 2'b00;
            coastOut(ch);
        end else if (killed[ch]) begin
            killed[ch] = 0;
            if (drives(mi)) begin
                coastLeft[ch] = DEAD; pending[ch] = mi; coastOut(ch);
            end else runOut(ch, mi, e);
        end else if (coastLeft[ch] > 0) begin
            if (!drives(mi)) begin
                coastLeft[ch] = 0; runOut(ch, mi, e);
            end else if (coastLeft[ch] == 1) begin
                coastLeft[ch] = 0; runOut(ch, pending[ch], e);
            end else begin
                coastLeft[ch]--; pending[ch] = mi; coastOut(ch);
            end
        end else if (drives(mi) && mi != onBridge[ch]) begin
            coastLeft[ch] = DEAD; pending[ch] = mi; coastOut(ch);
        end else runOut(ch, mi, e);
    endtask

    // One clock: update the model from the inputs present at the edge, then
    // check every output against it shortly after the edge.
    task automatic step();
        logic [1:0] m [2];
        bit rev;
        @(posedge MCLK);
        model(0, nRST, EnA_in, MotorA_in, KillA);
        model(1, nRST, EnB_in, MotorB_in, KillB);
        #1;
        m[0] = MotorA; m[1] = MotorB;
        chk("EnA", int'(EnA), int'(expEn[0]));
        chk("MotorA", int'(MotorA), int'(expMotor[0]));
        chk("BusyA", int'(BusyA), int'(expBusy[0]));
        chk("EnB", int'(EnB), int'(expEn[1]));
        chk("MotorB", int'(MotorB), int'(expMotor[1]));
        chk("BusyB", int'(BusyB), int'(expBusy[1]));
        for (int c = 0; c < 2; c++) begin
            rev = (prevMotor[c] == 2'b10 && m[c] == 2'b01) ||
                  (prevMotor[c] == 2'b01 && m[c] == 2'b10);
            chk(c == 0 ? "reversalA" : "reversalB", int'(rev), 0);
            prevMotor[c] = m[c];
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            coastLeft[c] = 0; killed[c] = 0; onBridge[c] = 0; pending[c] = 0;
            prevMotor[c] = 0;
        end

        // Reset state
        steps(2);
        chk("rstMotorA", int'(MotorA), 0);
        chk("rstBusyA", int'(BusyA), 0);
        chk("rstEnA", int'(EnA), 0);

        // First drive after reset: 4 coast cycles, then forward
        nRST = 1; MotorA_in = 2'b10; EnA_in = 1;
        for (int i = 0; i < DEAD; i++) begin
            step();
            chk("startCoastA", int'(MotorA), 0);
            chk("startBusyA", int'(BusyA), 1);
        end
        step();
        chk("startFwdA", int'(MotorA), 2);
        chk("startEnA", int'(EnA), 1);

        // Reverse from forward: exactly 4 coast cycles
        MotorA_in = 2'b01;
        for (int i = 0; i < DEAD; i++) begin
            step();
            chk("revCoastA", int'(MotorA), 0);
            chk("revEnA", int'(EnA), 0);
        end
        step();
        chk("revA", int'(MotorA), 1);
        chk("revBIdle", int'(MotorB), 0);

        // Coast and brake have no dead time
        MotorA_in = 2'b10; steps(DEAD + 1);
        MotorA_in = 2'b00; step();
        chk("coastA", int'(MotorA), 0); chk("coastBusyA", int'(BusyA), 0);
        MotorA_in = 2'b11; step();
        chk("brakeA", int'(MotorA), 3); chk("brakeBusyA", int'(BusyA), 0);

        // Retarget mid-dead keeps the original window
        MotorA_in = 2'b10; steps(DEAD + 1);
        MotorA_in = 2'b01; steps(2);
        MotorA_in = 2'b10; steps(2);
        chk("retgtCoastA", int'(MotorA), 0);
        step();
        chk("retgtA", int'(MotorA), 2);

        // Kill B for 3 cycles while running reverse
        MotorB_in = 2'b01; EnB_in = 1; steps(DEAD + 1);
        chk("bRunRev", int'(MotorB), 1);
        KillB = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("killMotorB", int'(MotorB), 0);
            chk("killEnB", int'(EnB), 0);
        end
        KillB = 0;
        for (int i = 0; i < DEAD; i++) begin
            step();
            chk("postKillCoastB", int'(MotorB), 0);
        end
        step();
        chk("postKillRevB", int'(MotorB), 1);

        // Reset during dead time drops the pending target
        MotorA_in = 2'b01; steps(2);
        nRST = 0; step();
        chk("midRstMotorA", int'(MotorA), 0);
        chk("midRstBusyA", int'(BusyA), 0);
        nRST = 1; MotorA_in = 2'b00;
        for (int i = 0; i < DEAD + 2; i++) begin
            step();
            chk("noOldTgtA", int'(MotorA), 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            nRST = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 5) == 0) MotorA_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) MotorB_in = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) EnA_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) EnB_in = 1'($urandom_range(0, 1));
            KillA = KillA ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
            KillB = KillB ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
